// File: rtl/sdp_ram_be.sv
// Simple dual-port RAM with byte enables and a self-clearing start-up sequence.
// Clears every word after reset, then serves one write and one read per cycle.
module sdp_ram_be #(
    parameter int WORDS   = 256,
    parameter int DW      = 32,
    parameter int RD_LAT  = 1,
    parameter int RDW_NEW = 1,
    localparam int AW     = $clog2(WORDS),
    localparam int NB     = DW / 8
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          init_busy,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [NB-1:0] wr_be,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;

    logic [DW-1:0] mem [WORDS];
    logic [NB-1:0] mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    logic          wr_ok, rd_ok, rd_acc;
    logic [NB-1:0] byp_be_d, byp_be_q;
    logic [DW-1:0] byp_data_q, byp_mask, rd_raw_q, stage1_data;
    logic          v1_q;

    // Only a non-power-of-two depth can see addresses past the end.
    generate
        if ((1 << AW) == WORDS) begin : g_full_range
            assign wr_ok = 1'b1;
            assign rd_ok = 1'b1;
        end else begin : g_part_range
            assign wr_ok = (wr_addr < AW'(WORDS));
            assign rd_ok = (rd_addr < AW'(WORDS));
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == INIT) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ADDR) begin
                state_d   = READY;
                clr_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign init_busy = (state_q == INIT);

    // The clear sequence owns the write port; user writes only in READY.
    always_comb begin
        mem_we    = '0;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        if (rst_n) begin
            if (state_q == INIT) begin
                mem_we = '1;
            end else if (wr_en && wr_ok) begin
                mem_we    = wr_be;
                mem_waddr = wr_addr;
                mem_wdata = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (mem_we[i]) begin
                mem[mem_waddr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
            end
        end
    end

    assign rd_acc   = rst_n && (state_q == READY) && rd_en;
    assign byp_be_d = ((RDW_NEW != 0) && wr_en && wr_ok && (wr_addr == rd_addr)) ? wr_be : '0;

    // The RAM read returns old data; colliding write lanes are merged after it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q       <= 1'b0;
            rd_raw_q   <= '0;
            byp_be_q   <= '0;
            byp_data_q <= '0;
        end else begin
            v1_q <= rd_acc;
            if (rd_acc) begin
                rd_raw_q   <= rd_ok ? mem[rd_addr] : '0;
                byp_be_q   <= byp_be_d;
                byp_data_q <= wr_data;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_mask
            assign byp_mask[gi*8 +: 8] = {8{byp_be_q[gi]}};
        end
    endgenerate

    assign stage1_data = (rd_raw_q & ~byp_mask) | (byp_data_q & byp_mask);

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DW-1:0] rd2_q;
            logic          v2_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v2_q  <= 1'b0;
                    rd2_q <= '0;
                end else begin
                    v2_q <= v1_q;
                    if (v1_q) begin
                        rd2_q <= stage1_data;
                    end
                end
            end
            assign rd_data  = rd2_q;
            assign rd_valid = v2_q;
        end else begin : g_lat1
            assign rd_data  = stage1_data;
            assign rd_valid = v1_q;
        end
    endgenerate

endmodule

// File: tb/tb_sdp_ram_be.sv
// Bench for sdp_ram_be: two instances (200 words/latency 1/new-data and
// 256 words/latency 2/old-data) share stimulus and are checked against a word-array model.
module tb_sdp_ram_be;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_addr = '0;

    logic        init_busy_a, rd_valid_a, init_busy_b, rd_valid_b;
    logic [31:0] rd_data_a, rd_data_b;

    always #5 clk = ~clk;

    sdp_ram_be #(.WORDS(200), .DW(32), .RD_LAT(1), .RDW_NEW(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .init_busy(init_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
    );

    sdp_ram_be #(.WORDS(256), .DW(32), .RD_LAT(2), .RDW_NEW(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .init_busy(init_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
    );

    typedef struct {
        logic        we;
        logic [7:0]  wa;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        re;
        logic [7:0]  ra;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    int total = 0;
    int passed = 0;
    int cyc = 0;

    // Model state, index 0 = instance A, 1 = instance B.
    logic [31:0] mmem [2][256];
    int          init_left [2];
    logic        pv [2][4];
    logic [31:0] pd [2][4];
    logic        tv [2][4];
    logic [31:0] te [2][4];
    int          tr [2][4];
    logic [31:0] last_data [2];
    logic        tab_on = 1'b0;
    logic [31:0] tab_exp [2];
    int          tab_row = 0;

    function automatic int words_k(input int k);
        return (k == 0) ? 200 : 256;
    endfunction

    function automatic int lat_k(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic bit rdw_k(input int k);
        return (k == 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_edge();
        logic [31:0] v;
        int s;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                init_left[k] = words_k(k);
                last_data[k] = '0;
                for (int j = 0; j < 4; j++) begin
                    pv[k][j] = 1'b0;
                    tv[k][j] = 1'b0;
                end
            end else if (init_left[k] != 0) begin
                init_left[k]--;
                if (init_left[k] == 0) begin
                    for (int a = 0; a < 256; a++) mmem[k][a] = '0;
                end
            end else begin
                if (rd_en) begin
                    v = (int'(rd_addr) < words_k(k)) ? mmem[k][rd_addr] : 32'h0;
                    if (rdw_k(k) && wr_en && wr_addr == rd_addr && int'(rd_addr) < words_k(k)) begin
                        for (int b = 0; b < 4; b++)
                            if (wr_be[b]) v[b*8 +: 8] = wr_data[b*8 +: 8];
                    end
                    s = (cyc + lat_k(k) - 1) % 4;
                    pv[k][s] = 1'b1;
                    pd[k][s] = v;
                    if (tab_on) begin
                        tv[k][s] = 1'b1;
                        te[k][s] = tab_exp[k];
                        tr[k][s] = tab_row;
                    end
                end
                if (wr_en && int'(wr_addr) < words_k(k)) begin
                    for (int b = 0; b < 4; b++)
                        if (wr_be[b]) mmem[k][wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic        b, vl;
        logic [31:0] d;
        int s;
        s = cyc % 4;
        for (int k = 0; k < 2; k++) begin
            b  = (k == 0) ? init_busy_a : init_busy_b;
            vl = (k == 0) ? rd_valid_a : rd_valid_b;
            d  = (k == 0) ? rd_data_a : rd_data_b;
            chk($sformatf("busy%0d", k), {31'b0, b}, {31'b0, init_left[k] != 0});
            chk($sformatf("valid%0d", k), {31'b0, vl}, {31'b0, pv[k][s]});
            if (pv[k][s]) begin
                last_data[k] = pd[k][s];
                pv[k][s] = 1'b0;
            end
            chk($sformatf("data%0d", k), d, last_data[k]);
            if (tv[k][s]) begin
                chk($sformatf("row%0d_valid%0d", tr[k][s], k), {31'b0, vl}, 32'd1);
                chk($sformatf("row%0d_data%0d", tr[k][s], k), d, te[k][s]);
                tv[k][s] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; wr_be = '0; wr_data = '0; wr_addr = '0; rd_addr = '0;
    endtask

    // mode 1: requests held throughout init; mode 2: reads for the first 4 cycles.
    task automatic wait_init(input int mode);
        int n = 0, na = -1, nb = -1, vcnt = 0;
        while ((na < 0 || nb < 0) && n < 400) begin
            idle();
            if (mode == 1 && init_busy_a && init_busy_b) begin
                rd_en = 1'b1; rd_addr = 8'd3;
                wr_en = (n >= 100); wr_addr = 8'd3; wr_be = 4'hF; wr_data = 32'hDEADBEEF;
            end else if (mode == 2 && n < 4) begin
                rd_en = 1'b1; rd_addr = 8'd5;
            end
            tick();
            n++;
            if (rd_valid_a || rd_valid_b) vcnt++;
            if (na < 0 && !init_busy_a) na = n;
            if (nb < 0 && !init_busy_b) nb = n;
        end
        idle();
        chk("init_len_a", na, 200);
        chk("init_len_b", nb, 256);
        chk("init_no_valid", vcnt, 0);
    endtask

    function automatic logic [7:0] pick();
        int r = $urandom_range(0, 2);
        if (r == 0) return 8'($urandom_range(0, 7));
        if (r == 1) return 8'($urandom_range(195, 215));
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tab [20];
        tab[0]  = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd0,   32'h0,        32'h0};
        tab[1]  = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd3,   32'h0,        32'h0};
        tab[2]  = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd199, 32'h0,        32'h0};
        tab[3]  = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd255, 32'h0,        32'h0};
        tab[4]  = '{1'b1, 8'd5,   4'hF, 32'hAABBCCDD, 1'b0, 8'd0,   32'h0,        32'h0};
        tab[5]  = '{1'b1, 8'd5,   4'h5, 32'h11223344, 1'b0, 8'd0,   32'h0,        32'h0};
        tab[6]  = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd5,   32'hAA22CC44, 32'hAA22CC44};
        tab[7]  = '{1'b1, 8'd5,   4'h0, 32'h12345678, 1'b1, 8'd5,   32'hAA22CC44, 32'hAA22CC44};
        tab[8]  = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd5,   32'hAA22CC44, 32'hAA22CC44};
        tab[9]  = '{1'b1, 8'd7,   4'h3, 32'hFFFFFFFF, 1'b1, 8'd7,   32'h0000FFFF, 32'h00000000};
        tab[10] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd7,   32'h0000FFFF, 32'h0000FFFF};
        tab[11] = '{1'b1, 8'd210, 4'hF, 32'hCAFEF00D, 1'b0, 8'd0,   32'h0,        32'h0};
        tab[12] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd210, 32'h0,        32'hCAFEF00D};
        tab[13] = '{1'b1, 8'd199, 4'hF, 32'h0BADBEEF, 1'b0, 8'd0,   32'h0,        32'h0};
        tab[14] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd199, 32'h0BADBEEF, 32'h0BADBEEF};
        tab[15] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd20,  32'h0,        32'h0};
        tab[16] = '{1'b1, 8'd20,  4'hF, 32'h55555555, 1'b1, 8'd21,  32'h0,        32'h0};
        tab[17] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd20,  32'h55555555, 32'h55555555};
        tab[18] = '{1'b1, 8'd30,  4'hF, 32'h01020304, 1'b1, 8'd5,   32'hAA22CC44, 32'hAA22CC44};
        tab[19] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd30,  32'h01020304, 32'h01020304};

        init_left[0] = 200;
        init_left[1] = 256;
        idle();
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_busy_a", {31'b0, init_busy_a}, 32'd1);
        chk("reset_data_b", rd_data_b, 32'h0);
        rst_n = 1'b1;
        wait_init(1);

        for (int i = 0; i < 20; i++) begin
            wr_en = tab[i].we; wr_addr = tab[i].wa; wr_be = tab[i].be; wr_data = tab[i].wd;
            rd_en = tab[i].re; rd_addr = tab[i].ra;
            tab_on = tab[i].re; tab_exp[0] = tab[i].ea; tab_exp[1] = tab[i].eb; tab_row = i;
            tick();
            tab_on = 1'b0;
        end
        idle();
        repeat (3) tick();

        // Back-to-back reads of addr 5, reset on the 4th.
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1; rd_addr = 8'd5;
            rst_n = (i != 3);
            tick();
        end
        chk("pulse_busy_a", {31'b0, init_busy_a}, 32'd1);
        chk("pulse_busy_b", {31'b0, init_busy_b}, 32'd1);
        chk("pulse_valid_b", {31'b0, rd_valid_b}, 32'd0);
        chk("pulse_data_b", rd_data_b, 32'h0);
        rst_n = 1'b1;
        wait_init(2);

        for (int i = 0; i < 600; i++) begin
            wr_en = 1'($urandom_range(0, 1));
            rd_en = 1'($urandom_range(0, 1));
            wr_addr = pick();
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : pick();
            wr_be = 4'($urandom);
            wr_data = $urandom;
            tick();
        end
        idle();
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
